// File: rtl/prio_arbiter.sv
// Registered N-way arbiter: fixed-priority or round-robin selection, one grant held
// until the holder pulses done, presented as index, one-hot vector and valid flag.
module prio_arbiter #(
  parameter int N  = 4,
  parameter int W  = $clog2(N),
  parameter bit RR = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [W-1:0] idx,
  output logic         V,
  output logic [N-1:0] gnt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_idx;
  logic [W-1:0]   w_idx_next;
  logic           r_v;
  logic           w_v_next;
  logic [N-1:0]   r_gnt;
  logic [N-1:0]   w_gnt_next;
  logic [W-1:0]   w_win;
  logic           w_take;

  // A new grant is accepted only from IDLE; done in the same cycle is irrelevant there.
  assign w_take = (r_state == S_IDLE) && (|req);

  generate
    if (RR) begin : g_rr
      logic [W-1:0] r_ptr;
      logic         w_found;

      // Search starts just after the last winner and wraps at N, not at 2^W.
      always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!w_found && req[(int'(r_ptr) + k) % N]) begin
            w_win   = W'((int'(r_ptr) + k) % N);
            w_found = 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ptr <= W'(N - 1);
        end else if (w_take) begin
          r_ptr <= w_win;
        end
      end
    end else begin : g_fixed
      // Later iterations overwrite earlier ones, so the highest set bit wins.
      always_comb begin
        w_win = '0;
        for (int i = 0; i < N; i++) begin
          if (req[i]) begin
            w_win = W'(i);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_v_next     = r_v;
    w_gnt_next   = r_gnt;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_next = S_GRANT;
          w_idx_next   = w_win;
          w_v_next     = 1'b1;
          w_gnt_next   = {{(N-1){1'b0}}, 1'b1} << w_win;
        end else begin
          w_v_next   = 1'b0;
          w_gnt_next = '0;
        end
      end
      S_GRANT: begin
        if (done) begin
          w_state_next = S_IDLE;
          w_v_next     = 1'b0;
          w_gnt_next   = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_v_next     = 1'b0;
        w_gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_v     <= 1'b0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_v     <= w_v_next;
      r_gnt   <= w_gnt_next;
    end
  end

  assign idx = r_idx;
  assign V   = r_v;
  assign gnt = r_gnt;

endmodule
